// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state, digit types and preset validation for the BCD countdown timer
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;
   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_NINE     = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   // Seconds tens <= 5 with valid ones is the same as seconds <= 59.
   function automatic logic preset_ok(input logic [7:0] pm, input logic [7:0] ps,
                                      input logic [7:0] min_max);
      preset_ok = (pm[7:4] <= BCD_NINE) && (pm[3:0] <= BCD_NINE) &&
                  (ps[7:4] <= SEC_TENS_MAX) && (ps[3:0] <= BCD_NINE) &&
                  (pm <= min_max);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - one BCD digit decrementer; wraps to WRAP and borrows when leaving zero
module bcd_digit_dec
   import timer_pkg::*;
#(
   parameter logic [3:0] WRAP = 4'd9
) (
   input  logic [3:0] digit,
   input  logic       dec_en,
   output logic [3:0] next_digit,
   output logic       borrow_out
);

   always_comb begin
      next_digit = digit;
      borrow_out = 1'b0;
      if (dec_en) begin
         if (digit == 4'd0) begin
            next_digit = WRAP;
            borrow_out = 1'b1;
         end else begin
            next_digit = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - MM:SS BCD countdown with load/start/pause/clear and done blink
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter logic [7:0] MIN_MAX   = 8'h99,
   parameter int         DONE_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic [7:0] preset_min,
   input  logic [7:0] preset_sec,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       run_en,
   output logic       done,
   output logic       done_pulse,
   output logic       load_err,
   output logic       done_blink
);

   localparam int         CW   = $clog2(DONE_HOLD + 1);
   localparam logic [CW-1:0] HOLD = CW'(DONE_HOLD);

   timer_state_t  state, state_nxt;
   logic [7:0]    min_nxt, sec_nxt, min_dec, sec_dec;
   logic          pulse_nxt, err_nxt, blink_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          b_so, b_st, b_mo, b_mt;
   logic          nonzero, ok, expire;

   // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
   bcd_digit_dec #(.WRAP(BCD_NINE)) u_sec_ones (
      .digit(sec_bcd[3:0]), .dec_en(1'b1), .next_digit(sec_dec[3:0]), .borrow_out(b_so));
   bcd_digit_dec #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
      .digit(sec_bcd[7:4]), .dec_en(b_so), .next_digit(sec_dec[7:4]), .borrow_out(b_st));
   bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_ones (
      .digit(min_bcd[3:0]), .dec_en(b_st), .next_digit(min_dec[3:0]), .borrow_out(b_mo));
   bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_tens (
      .digit(min_bcd[7:4]), .dec_en(b_mo), .next_digit(min_dec[7:4]), .borrow_out(b_mt));

   assign nonzero = (min_bcd != 8'h00) || (sec_bcd != 8'h00);
   assign ok      = preset_ok(preset_min, preset_sec, MIN_MAX);
   assign expire  = !b_mt && (min_dec == 8'h00) && (sec_dec == 8'h00);

   always_comb begin
      state_nxt = state;
      min_nxt   = min_bcd;
      sec_nxt   = sec_bcd;
      pulse_nxt = 1'b0;
      err_nxt   = 1'b0;
      blink_nxt = done_blink;
      cnt_nxt   = cnt;
      if (clear) begin
         state_nxt = IDLE;
         min_nxt   = 8'h00;
         sec_nxt   = 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start && nonzero) begin
                  state_nxt = RUN;
               end else if (load) begin
                  if (ok) begin
                     min_nxt = preset_min;
                     sec_nxt = preset_sec;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
            RUN: begin
               if (pause) begin
                  state_nxt = PAUSE;
               end else if (tick) begin
                  min_nxt = min_dec;
                  sec_nxt = sec_dec;
                  if (expire) begin
                     state_nxt = DONE;
                     pulse_nxt = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (start && nonzero) begin
                  state_nxt = RUN;
               end else if (load) begin
                  if (ok) begin
                     min_nxt = preset_min;
                     sec_nxt = preset_sec;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
            DONE: begin
               if (tick) begin
                  if (cnt < HOLD) begin
                     cnt_nxt   = cnt + CW'(1);
                     blink_nxt = (cnt_nxt == HOLD) ? 1'b0 : !done_blink;
                  end
               end else if (load) begin
                  if (ok) begin
                     min_nxt   = preset_min;
                     sec_nxt   = preset_sec;
                     state_nxt = IDLE;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      // Blink state only lives inside DONE, so entry always starts from zero.
      if (state_nxt != DONE) begin
         blink_nxt = 1'b0;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         min_bcd    <= 8'h00;
         sec_bcd    <= 8'h00;
         run_en     <= 1'b0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         load_err   <= 1'b0;
         done_blink <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_nxt;
         min_bcd    <= min_nxt;
         sec_bcd    <= sec_nxt;
         run_en     <= (state_nxt == RUN);
         done       <= (state_nxt == DONE);
         done_pulse <= pulse_nxt;
         load_err   <= err_nxt;
         done_blink <= blink_nxt;
         cnt        <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [7:0] preset_min = 8'h00, preset_sec = 8'h00;
   logic [7:0] min_bcd, sec_bcd;
   logic       run_en, done, done_pulse, load_err, done_blink;

   int n_checks = 0;
   int n_fail   = 0;

   // Output vector order: {min, sec, run_en, done, done_pulse, load_err, done_blink}
   logic [20:0] exp_q[$];

   localparam logic [4:0] N = 5'b00000, T = 5'b10000, L = 5'b01000,
                          S = 5'b00100, P = 5'b00010, C = 5'b00001;

   typedef struct {
      logic [4:0]  ctl;
      logic [7:0]  pm;
      logic [7:0]  ps;
      logic [20:0] exp;
   } step_t;

   bcd_countdown_timer #(.MIN_MAX(8'h99), .DONE_HOLD(8)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .start(start),
      .pause(pause), .clear(clear), .preset_min(preset_min), .preset_sec(preset_sec),
      .min_bcd(min_bcd), .sec_bcd(sec_bcd), .run_en(run_en), .done(done),
      .done_pulse(done_pulse), .load_err(load_err), .done_blink(done_blink));

   always #5 clk = ~clk;

   function automatic logic [20:0] ex(input logic [7:0] m, input logic [7:0] s, input logic r,
                                      input logic d, input logic dp, input logic le, input logic bl);
      ex = {m, s, r, d, dp, le, bl};
   endfunction

   function automatic logic [20:0] outv();
      outv = {min_bcd, sec_bcd, run_en, done, done_pulse, load_err, done_blink};
   endfunction

   function automatic step_t mk(input logic [4:0] ctl, input logic [7:0] pm, input logic [7:0] ps,
                                input logic [20:0] e);
      mk.ctl = ctl; mk.pm = pm; mk.ps = ps; mk.exp = e;
   endfunction

   task automatic apply(input step_t st);
      {tick, load, start, pause, clear} = st.ctl;
      preset_min = st.pm;
      preset_sec = st.ps;
      @(posedge clk);
      #1;
      {tick, load, start, pause, clear} = 5'b0;
   endtask

   task automatic test_reset();
      logic [20:0] e;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(ex(8'h00, 8'h00, 0, 0, 0, 0, 0));
      e = exp_q.pop_front();
      n_checks++;
      if (outv() !== e) begin
         n_fail++;
         $display("FAIL reset: got %h expected %h", outv(), e);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_count();
      step_t s[$];
      logic [20:0] e;
      logic [7:0] secs[6] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};
      logic [7:0] mins[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
      s.push_back(mk(L, 8'h01, 8'h05, ex(8'h01, 8'h05, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h01, 8'h05, 1, 0, 0, 0, 0)));
      for (int k = 0; k < 6; k++)
         s.push_back(mk(T, 8'h00, 8'h00, ex(mins[k], secs[k], 1, 0, 0, 0, 0)));
      foreach (s[i]) begin
         exp_q.push_back(s[i].exp);
         apply(s[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL count step %0d: got %h expected %h", i, outv(), e);
         end
      end
   endtask

   task automatic test_expiry();
      step_t s[$];
      logic [20:0] e;
      s.push_back(mk(C, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(L, 8'h00, 8'h02, ex(8'h00, 8'h02, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h02, 1, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h00, 8'h01, 1, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 1, 1, 0, 0)));
      s.push_back(mk(N, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 1, 0, 0, 0)));
      for (int k = 1; k <= 10; k++)
         s.push_back(mk(T, 8'h00, 8'h00,
                        ex(8'h00, 8'h00, 0, 1, 0, 0, (k < 8) && (k % 2 == 1))));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 1, 0, 0, 0)));
      s.push_back(mk(L, 8'h00, 8'h03, ex(8'h00, 8'h03, 0, 0, 0, 0, 0)));
      foreach (s[i]) begin
         exp_q.push_back(s[i].exp);
         apply(s[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL expiry step %0d: got %h expected %h", i, outv(), e);
         end
      end
   endtask

   task automatic test_load_err();
      step_t s[$];
      logic [20:0] e;
      s.push_back(mk(C, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(L, 8'h00, 8'h60, ex(8'h00, 8'h00, 0, 0, 0, 1, 0)));
      s.push_back(mk(N, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(L, 8'h1A, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 1, 0)));
      s.push_back(mk(L, 8'h99, 8'h59, ex(8'h99, 8'h59, 0, 0, 0, 0, 0)));
      s.push_back(mk(L, 8'h00, 8'h5A, ex(8'h99, 8'h59, 0, 0, 0, 1, 0)));
      s.push_back(mk(C, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(N, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      foreach (s[i]) begin
         exp_q.push_back(s[i].exp);
         apply(s[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL load_err step %0d: got %h expected %h", i, outv(), e);
         end
      end
   endtask

   task automatic test_pause();
      step_t s[$];
      logic [20:0] e;
      s.push_back(mk(L, 8'h00, 8'h10, ex(8'h00, 8'h10, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h10, 1, 0, 0, 0, 0)));
      s.push_back(mk(T | P, 8'h00, 8'h00, ex(8'h00, 8'h10, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h10, 1, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h00, 8'h09, 1, 0, 0, 0, 0)));
      s.push_back(mk(L, 8'h00, 8'h30, ex(8'h00, 8'h09, 1, 0, 0, 0, 0)));
      s.push_back(mk(P, 8'h00, 8'h00, ex(8'h00, 8'h09, 0, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h00, 8'h09, 0, 0, 0, 0, 0)));
      s.push_back(mk(L, 8'h00, 8'h30, ex(8'h00, 8'h30, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h30, 1, 0, 0, 0, 0)));
      s.push_back(mk(C, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      foreach (s[i]) begin
         exp_q.push_back(s[i].exp);
         apply(s[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL pause step %0d: got %h expected %h", i, outv(), e);
         end
      end
   endtask

   task automatic test_borrow_async_reset();
      step_t s[$];
      logic [20:0] e;
      s.push_back(mk(L, 8'h10, 8'h00, ex(8'h10, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h10, 8'h00, 1, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h09, 8'h59, 1, 0, 0, 0, 0)));
      foreach (s[i]) begin
         exp_q.push_back(s[i].exp);
         apply(s[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL borrow step %0d: got %h expected %h", i, outv(), e);
         end
      end
      #2 rst_n = 1'b0;
      exp_q.push_back(ex(8'h00, 8'h00, 0, 0, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (outv() !== e) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", outv(), e);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_clear();
      step_t s[$];
      logic [20:0] e;
      s.push_back(mk(L, 8'h00, 8'h02, ex(8'h00, 8'h02, 0, 0, 0, 0, 0)));
      s.push_back(mk(S, 8'h00, 8'h00, ex(8'h00, 8'h02, 1, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h00, 8'h01, 1, 0, 0, 0, 0)));
      s.push_back(mk(T | C, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(N, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      s.push_back(mk(T, 8'h00, 8'h00, ex(8'h00, 8'h00, 0, 0, 0, 0, 0)));
      foreach (s[i]) begin
         exp_q.push_back(s[i].exp);
         apply(s[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL clear step %0d: got %h expected %h", i, outv(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_expiry();
      test_load_err();
      test_pause();
      test_borrow_async_reset();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
